dstack_spill_controller: RTL and testbench

DSTACK_SPILL_CONTROLLER -- requirements
Module: dstack_spill_controller

---
 rtl/dstack_spill_controller_if.sv | 21 ++
 rtl/dstack_spill_controller.sv | 159 +++++++++++++++
 tb/tb_dstack_spill_controller.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dstack_spill_controller_if.sv
// rtl/dstack_spill_controller_if.sv - memory request bus between the spill controller and the backing store
interface dstack_spill_controller_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [WORD_WIDTH-1:0] mem_addr;
    logic [WORD_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [WORD_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dstack_spill_controller.sv
// rtl/dstack_spill_controller.sv - on-chip data-stack buffer that spills to / fills from memory
module dstack_spill_controller #(
    parameter int WORD_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int HIGH_MARK  = DEPTH - 2,
    parameter int LOW_MARK   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [1:0]                i_movement,
    input  logic [WORD_WIDTH-1:0]     i_push_data,
    output logic [WORD_WIDTH-1:0]     o_pop_data,
    output logic [WORD_WIDTH-1:0]     o_pop_data2,
    output logic                      o_stall,
    input  logic [WORD_WIDTH-1:0]     i_base_addr,
    dstack_spill_controller_if.master mem,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic [WORD_WIDTH-1:0]     o_mem_depth,
    output logic                      o_underflow
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
    localparam logic [CW-1:0] C_DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] C_HIGH     = CW'(HIGH_MARK);
    localparam logic [CW-1:0] C_LOW      = CW'(LOW_MARK);

    typedef enum logic [1:0] {ST_IDLE, ST_SPILL, ST_FILL} state_t;

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_buf [DEPTH];
    logic [PW-1:0]         r_top;
    logic [PW-1:0]         r_bot;
    logic [CW-1:0]         r_count;
    logic [WORD_WIDTH-1:0] r_mem_depth;
    logic                  r_underflow;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [WORD_WIDTH-1:0] r_mem_addr;
    logic [WORD_WIDTH-1:0] r_mem_wdata;

    logic                  w_push;
    logic                  w_pop;
    logic [CW-1:0]         w_pop_n;
    logic                  w_mem_nonzero;
    logic                  w_short;
    logic                  w_stall;
    logic                  w_underflow_hit;
    logic                  w_accept_push;
    logic                  w_accept_pop;
    logic [CW-1:0]         w_pop_amt;
    logic                  w_ack;
    logic                  w_spill_ack;
    logic                  w_fill_ack;
    logic [CW-1:0]         w_count_next;
    logic [PW-1:0]         w_top_next;
    logic [PW-1:0]         w_bot_next;
    logic [PW-1:0]         w_bot_below;
    logic [WORD_WIDTH-1:0] w_mem_depth_next;

    assign w_push        = (i_movement == 2'b01);
    assign w_pop         = i_movement[1];
    assign w_pop_n       = (i_movement == 2'b11) ? CW'(2) : (i_movement == 2'b10) ? CW'(1) : '0;
    assign w_mem_nonzero = |r_mem_depth;
    assign w_short       = (r_count < w_pop_n);

    // A pending fill needs the slot just below bottom, so the last free slot is reserved for it.
    assign w_stall = (w_push && r_count == C_DEPTH)
                   || (w_push && r_state == ST_FILL && r_count == C_DEPTH_M1)
                   || (w_pop && w_short && w_mem_nonzero)
                   || (w_pop && r_state == ST_SPILL && r_count <= w_pop_n);

    assign w_underflow_hit = w_pop && w_short && !w_mem_nonzero && !w_stall;
    assign w_accept_push   = w_push && !w_stall;
    assign w_accept_pop    = w_pop && !w_stall && !w_underflow_hit;
    assign w_pop_amt       = w_accept_pop ? w_pop_n : '0;

    // Acks outside an active request (idle, or after reset) are dropped here.
    assign w_ack       = mem.mem_ack && r_mem_req;
    assign w_spill_ack = w_ack && (r_state == ST_SPILL);
    assign w_fill_ack  = w_ack && (r_state == ST_FILL);

    assign w_count_next     = r_count + CW'(w_accept_push) + CW'(w_fill_ack) - CW'(w_spill_ack) - w_pop_amt;
    assign w_top_next       = r_top + PW'(w_accept_push) - w_pop_amt[PW-1:0];
    assign w_bot_next       = r_bot + PW'(w_spill_ack) - PW'(w_fill_ack);
    assign w_bot_below      = r_bot - PW'(1);
    assign w_mem_depth_next = r_mem_depth + WORD_WIDTH'(w_spill_ack) - WORD_WIDTH'(w_fill_ack);

    always_ff @(posedge clk) begin
        if (w_accept_push) begin
            r_buf[r_top] <= i_push_data;
        end
        if (w_fill_ack) begin
            r_buf[w_bot_below] <= mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_top       <= '0;
            r_bot       <= '0;
            r_count     <= '0;
            r_mem_depth <= '0;
            r_underflow <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_top       <= w_top_next;
            r_bot       <= w_bot_next;
            r_count     <= w_count_next;
            r_mem_depth <= w_mem_depth_next;
            if (w_underflow_hit) begin
                r_underflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_count >= C_HIGH) begin
                        r_state     <= ST_SPILL;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= i_base_addr + r_mem_depth;
                        r_mem_wdata <= r_buf[r_bot];
                    end else if (r_count <= C_LOW && w_mem_nonzero) begin
                        r_state    <= ST_FILL;
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= i_base_addr + r_mem_depth - WORD_WIDTH'(1);
                    end
                end
                ST_SPILL, ST_FILL: begin
                    if (w_ack) begin
                        r_state   <= ST_IDLE;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    assign o_pop_data    = r_buf[r_top - PW'(1)];
    assign o_pop_data2   = r_buf[r_top - PW'(2)];
    assign o_stall       = w_stall;
    assign o_count       = r_count;
    assign o_mem_depth   = r_mem_depth;
    assign o_underflow   = r_underflow;
    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_dstack_spill_controller.sv
// tb/tb_dstack_spill_controller.sv - randomized and directed bench with a queue-based stack model
module tb_dstack_spill_controller;
    localparam int DEPTH = 16;
    localparam int HM    = DEPTH - 2;
    localparam int LM    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  movement;
    logic [31:0] push_data;
    logic [31:0] base_addr;
    logic [31:0] o_pop_data;
    logic [31:0] o_pop_data2;
    logic        o_stall;
    logic [4:0]  o_count;
    logic [31:0] o_mem_depth;
    logic        o_underflow;

    dstack_spill_controller_if #(.WORD_WIDTH(32)) mem_bus ();

    dstack_spill_controller #(.WORD_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_movement  (movement),
        .i_push_data (push_data),
        .o_pop_data  (o_pop_data),
        .o_pop_data2 (o_pop_data2),
        .o_stall     (o_stall),
        .i_base_addr (base_addr),
        .mem         (mem_bus),
        .o_count     (o_count),
        .o_mem_depth (o_mem_depth),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    // Model: q holds on-chip words bottom-first, mq holds spilled words by offset from base.
    logic [31:0] q[$];
    logic [31:0] mq[$];
    int          pend;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    int          n_checks = 0;
    int          n_pass   = 0;

    function automatic bit exp_stall(input logic [1:0] mv);
        int c = q.size();
        int md = mq.size();
        int n = (mv == 2'b11) ? 2 : (mv == 2'b10) ? 1 : 0;
        if (mv == 2'b01) return (c == DEPTH) || (pend == 2 && c == DEPTH - 1);
        if (n > 0) return (c < n && md > 0) || (pend == 1 && c - n < 1);
        return 1'b0;
    endfunction

    task automatic model_clear();
        q.delete();
        mq.delete();
        pend = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        movement = 2'b00;
        push_data = '0;
        mem_bus.mem_ack = 1'b0;
        mem_bus.mem_rdata = '0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic drive(input logic [1:0] mv, input bit ack, input logic [31:0] pd, input logic [31:0] rd);
        @(negedge clk);
        movement = mv;
        push_data = pd;
        mem_bus.mem_ack = ack;
        mem_bus.mem_rdata = rd;
        #1;
    endtask

    task automatic advance();
        int c = q.size();
        int md = mq.size();
        int n = (movement == 2'b11) ? 2 : (movement == 2'b10) ? 1 : 0;
        bit st = exp_stall(movement);
        bit ufc = (n > 0) && (c < n) && (md == 0) && !st;
        bit ack_eff = mem_bus.mem_ack && (pend != 0);
        @(posedge clk);
        if (pend == 0) begin
            if (c >= HM) begin
                pend = 1;
                lat_addr = base_addr + 32'(md);
                lat_data = q[0];
            end else if (c <= LM && md > 0) begin
                pend = 2;
                lat_addr = base_addr + 32'(md) - 32'd1;
            end
        end else if (ack_eff) begin
            if (pend == 1) mq.push_back(q.pop_front());
            else begin
                q.push_front(mem_bus.mem_rdata);
                void'(mq.pop_back());
            end
            pend = 0;
        end
        if (!st && !ufc) begin
            if (movement == 2'b01) q.push_back(push_data);
            else repeat (n) void'(q.pop_back());
        end
        #1;
    endtask

    task automatic step(input logic [1:0] mv, input bit ack, input logic [31:0] pd);
        drive(mv, ack, pd, 32'h0);
        advance();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (o_count !== 5'd0) $display("FAIL reset_count got %0d exp 0", o_count); else n_pass++;
        n_checks++; if (o_mem_depth !== 32'd0) $display("FAIL reset_mem_depth got %0d exp 0", o_mem_depth); else n_pass++;
        n_checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL reset_mem_req got %b exp 0", mem_bus.mem_req); else n_pass++;
        n_checks++; if (mem_bus.mem_we !== 1'b0) $display("FAIL reset_mem_we got %b exp 0", mem_bus.mem_we); else n_pass++;
        n_checks++; if (o_underflow !== 1'b0) $display("FAIL reset_underflow got %b exp 0", o_underflow); else n_pass++;
        n_checks++; if (o_stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", o_stall); else n_pass++;
    endtask

    task automatic test_spill();
        base_addr = 32'h40;
        do_reset();
        for (int i = 1; i <= 14; i++) step(2'b01, 1'b0, 32'(i));
        drive(2'b00, 1'b0, 0, 0);
        n_checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL spill_req_early got %b exp 0", mem_bus.mem_req); else n_pass++;
        advance();
        n_checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1) $display("FAIL spill_req got %b/%b exp 1/1", mem_bus.mem_req, mem_bus.mem_we); else n_pass++;
        n_checks++; if (mem_bus.mem_addr !== 32'h40) $display("FAIL spill_addr got %h exp 40", mem_bus.mem_addr); else n_pass++;
        n_checks++; if (mem_bus.mem_wdata !== 32'd1) $display("FAIL spill_wdata got %0d exp 1", mem_bus.mem_wdata); else n_pass++;
        step(2'b00, 1'b0, 0);
        drive(2'b00, 1'b1, 0, 0);
        n_checks++; if (mem_bus.mem_addr !== 32'h40 || mem_bus.mem_wdata !== 32'd1) $display("FAIL spill_stable got %h/%0d exp 40/1", mem_bus.mem_addr, mem_bus.mem_wdata); else n_pass++;
        advance();
        n_checks++; if (o_count !== 5'd13) $display("FAIL spill_count got %0d exp 13", o_count); else n_pass++;
        n_checks++; if (o_mem_depth !== 32'd1) $display("FAIL spill_mem_depth got %0d exp 1", o_mem_depth); else n_pass++;
        n_checks++; if (mem_bus.mem_req !== 1'b0) $display("FAIL spill_idle_gap got %b exp 0", mem_bus.mem_req); else n_pass++;
    endtask

    task automatic test_full_stall();
        for (int i = 15; i <= 17; i++) step(2'b01, 1'b0, 32'(i));
        n_checks++; if (o_count !== 5'd16 || mem_bus.mem_req !== 1'b1) $display("FAIL full_setup got %0d/%b exp 16/1", o_count, mem_bus.mem_req); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            drive(2'b01, 1'b0, 32'd18, 0);
            n_checks++; if (o_stall !== 1'b1) $display("FAIL full_stall cycle %0d got %b exp 1", k, o_stall); else n_pass++;
            advance();
        end
        drive(2'b01, 1'b1, 32'd18, 0);
        n_checks++; if (o_stall !== 1'b1) $display("FAIL full_stall_ack got %b exp 1", o_stall); else n_pass++;
        advance();
        drive(2'b01, 1'b0, 32'd18, 0);
        n_checks++; if (o_stall !== 1'b0) $display("FAIL full_push_after_ack got %b exp 0", o_stall); else n_pass++;
        advance();
        n_checks++; if (o_count !== 5'd16 || o_mem_depth !== 32'd2) $display("FAIL full_count got %0d/%0d exp 16/2", o_count, o_mem_depth); else n_pass++;
        n_checks++; if (mem_bus.mem_addr !== 32'h42 || mem_bus.mem_wdata !== 32'd3) $display("FAIL full_next_spill got %h/%0d exp 42/3", mem_bus.mem_addr, mem_bus.mem_wdata); else n_pass++;
    endtask

    task automatic test_fill();
        int v = 1;
        bit ok = 1'b0;
        base_addr = 32'h100;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            if (pend == 1 && mq.size() >= 2) begin ok = 1'b1; break; end
            if (pend == 1) step(2'b00, 1'b1, 0);
            else begin step(2'b01, 1'b0, 32'(v)); v++; end
        end
        n_checks++; if (!ok) $display("FAIL fill_setup_timeout got 0 exp 1"); else n_pass++;
        while (q.size() > 5) step(2'b11, 1'b0, 0);
        step(2'b00, 1'b1, 0);
        while (q.size() > 2) step(2'b10, 1'b0, 0);
        step(2'b00, 1'b0, 0);
        n_checks++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b0) $display("FAIL fill_req got %b/%b exp 1/0", mem_bus.mem_req, mem_bus.mem_we); else n_pass++;
        n_checks++; if (mem_bus.mem_addr !== 32'h102) $display("FAIL fill_addr got %h exp 102", mem_bus.mem_addr); else n_pass++;
        n_checks++; if (o_count !== 5'd2 || o_mem_depth !== 32'd3) $display("FAIL fill_pre got %0d/%0d exp 2/3", o_count, o_mem_depth); else n_pass++;
        step(2'b00, 1'b0, 0);
        drive(2'b00, 1'b1, 0, 32'hAB);
        advance();
        n_checks++; if (o_count !== 5'd3 || o_mem_depth !== 32'd2) $display("FAIL fill_post got %0d/%0d exp 3/2", o_count, o_mem_depth); else n_pass++;
        step(2'b11, 1'b0, 0);
        n_checks++; if (o_pop_data !== 32'hAB) $display("FAIL fill_bottom_entry got %h exp ab", o_pop_data); else n_pass++;
    endtask

    task automatic test_pop_two_stall();
        bit done = 1'b0;
        logic [31:0] rv = $urandom;
        for (int k = 0; k < 30; k++) begin
            drive(2'b11, pend == 2, 0, rv);
            if (k == 0) begin
                n_checks++; if (o_stall !== 1'b1 || o_count !== 5'd1) $display("FAIL pop2_first got %b/%0d exp 1/1", o_stall, o_count); else n_pass++;
            end
            if (o_stall === 1'b0) begin
                n_checks++; if (o_pop_data2 !== rv || o_pop_data !== 32'hAB) $display("FAIL pop2_data got %h/%h exp %h/ab", o_pop_data2, o_pop_data, rv); else n_pass++;
                done = 1'b1;
                advance();
                break;
            end
            advance();
        end
        n_checks++; if (!done) $display("FAIL pop2_timeout got 0 exp 1"); else n_pass++;
        n_checks++; if (o_count !== 5'd0 || o_mem_depth !== 32'd1) $display("FAIL pop2_after got %0d/%0d exp 0/1", o_count, o_mem_depth); else n_pass++;
    endtask

    task automatic test_underflow();
        do_reset();
        drive(2'b10, 1'b0, 0, 0);
        n_checks++; if (o_stall !== 1'b0) $display("FAIL uf_stall got %b exp 0", o_stall); else n_pass++;
        advance();
        n_checks++; if (o_count !== 5'd0 || o_underflow !== 1'b1) $display("FAIL uf_set got %0d/%b exp 0/1", o_count, o_underflow); else n_pass++;
        step(2'b01, 1'b0, 32'h5);
        step(2'b00, 1'b0, 0);
        n_checks++; if (o_underflow !== 1'b1 || o_count !== 5'd1) $display("FAIL uf_sticky got %b/%0d exp 1/1", o_underflow, o_count); else n_pass++;
    endtask

    task automatic test_reset_mid_spill();
        do_reset();
        for (int i = 1; i <= 14; i++) step(2'b01, 1'b0, 32'(i));
        step(2'b00, 1'b0, 0);
        n_checks++; if (mem_bus.mem_req !== 1'b1) $display("FAIL rst_spill_setup got %b exp 1", mem_bus.mem_req); else n_pass++;
        reset = 1'b1;
        model_clear();
        #1;
        n_checks++; if (mem_bus.mem_req !== 1'b0 || o_count !== 5'd0) $display("FAIL rst_async got %b/%0d exp 0/0", mem_bus.mem_req, o_count); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        drive(2'b00, 1'b1, 0, 32'hDEAD);
        advance();
        step(2'b00, 1'b0, 0);
        n_checks++; if (o_count !== 5'd0 || o_mem_depth !== 32'd0 || mem_bus.mem_req !== 1'b0) $display("FAIL rst_stray_ack got %0d/%0d/%b exp 0/0/0", o_count, o_mem_depth, mem_bus.mem_req); else n_pass++;
    endtask

    task automatic test_random();
        int bias = 0;
        base_addr = $urandom & 32'hFFFF_FFF0;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int r = $urandom_range(0, 99);
            logic [1:0] mv;
            bit ack;
            logic [31:0] rd;
            if (cyc % 64 == 0) bias = $urandom_range(0, 2);
            if (bias == 0) mv = (r < 60) ? 2'b01 : (r < 75) ? 2'b10 : (r < 85) ? 2'b11 : 2'b00;
            else if (bias == 1) mv = (r < 20) ? 2'b01 : (r < 55) ? 2'b10 : (r < 80) ? 2'b11 : 2'b00;
            else mv = 2'(r % 4);
            ack = (pend != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rd = (pend == 2) ? mq[mq.size() - 1] : $urandom;
            drive(mv, ack, $urandom, rd);
            n_checks++; if (o_stall !== exp_stall(mv)) $display("FAIL rnd_stall cyc %0d got %b exp %b", cyc, o_stall, exp_stall(mv)); else n_pass++;
            n_checks++; if (o_count !== 5'(q.size())) $display("FAIL rnd_count cyc %0d got %0d exp %0d", cyc, o_count, q.size()); else n_pass++;
            n_checks++; if (o_mem_depth !== 32'(mq.size())) $display("FAIL rnd_mem_depth cyc %0d got %0d exp %0d", cyc, o_mem_depth, mq.size()); else n_pass++;
            n_checks++; if (mem_bus.mem_req !== (pend != 0)) $display("FAIL rnd_req cyc %0d got %b exp %b", cyc, mem_bus.mem_req, pend != 0); else n_pass++;
            if (pend != 0) begin
                n_checks++; if (mem_bus.mem_we !== (pend == 1) || mem_bus.mem_addr !== lat_addr) $display("FAIL rnd_mem cyc %0d got %b/%h exp %b/%h", cyc, mem_bus.mem_we, mem_bus.mem_addr, pend == 1, lat_addr); else n_pass++;
            end
            if (pend == 1) begin
                n_checks++; if (mem_bus.mem_wdata !== lat_data) $display("FAIL rnd_wdata cyc %0d got %h exp %h", cyc, mem_bus.mem_wdata, lat_data); else n_pass++;
            end
            if (q.size() >= 1) begin
                n_checks++; if (o_pop_data !== q[q.size() - 1]) $display("FAIL rnd_pop_data cyc %0d got %h exp %h", cyc, o_pop_data, q[q.size() - 1]); else n_pass++;
            end
            if (q.size() >= 2) begin
                n_checks++; if (o_pop_data2 !== q[q.size() - 2]) $display("FAIL rnd_pop_data2 cyc %0d got %h exp %h", cyc, o_pop_data2, q[q.size() - 2]); else n_pass++;
            end
            advance();
        end
    endtask

    initial begin
        reset = 1'b1;
        base_addr = '0;
        model_clear();
        test_reset();
        test_spill();
        test_full_stall();
        test_fill();
        test_pop_two_stall();
        test_underflow();
        test_reset_mid_spill();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end
endmodule
